bird_round_keeper: RTL
======================

// Module: bird_round_keeper
// PURPOSE
//  Parametrised successor of the single-count bird keeper. Tracks birds shot and birds
//  escaped across a configurable round. Produces round pass/fail and multi-round
//  progression with a sticky game-over. Sits between the duck sprite logic (hit /
//  flew-away pulses) and the top-level game FSM, which starts rounds and acks results.
// PARAMETERS
//  BIRDS_PER_ROUND  10  birds released per round; legal range 1 .. 2**CNT_W-1
//  PASS_HITS        6   minimum hits to pass a round; must be <= BIRDS_PER_ROUND
//  MAX_ROUNDS       8   last playable round; passing it ends the game; must be >= 1
//  CNT_W            8   width of hits/misses/birds_used/round_num counters
// PORTS
//  Clk           in   1      system clock
//  Reset         in   1      synchronous, active-high reset
//  start_round   in   1      level; sampled only in IDLE
//  bird_hit      in   1      level from sprite logic; counted on rising edge
//  flew_away     in   1      level from sprite logic; counted on rising edge
//  round_ack     in   1      level; sampled only in ROUND_END
//  state         out  2      00 IDLE, 01 ACTIVE, 10 ROUND_END, 11 GAME_OVER
//  hits          out  CNT_W  hits this round
//  misses        out  CNT_W  escapes this round
//  birds_used    out  CNT_W  hits + misses
//  birds_left    out  CNT_W  BIRDS_PER_ROUND - birds_used
//  round_num     out  CNT_W  current round, 0-based
//  round_over    out  1      high while state == ROUND_END
//  round_passed  out  1      valid in ROUND_END/GAME_OVER: hits >= PASS_HITS
//  game_over     out  1      high while state == GAME_OVER
// BEHAVIOUR
//  - Reset: state=IDLE; hits=misses=birds_used=round_num=0; birds_left=BIRDS_PER_ROUND.
//    round_over=round_passed=game_over=0. Edge-detect history regs cleared to 0.
//  - Edge detect: hit_e = bird_hit & ~hit_q, fly_e = flew_away & ~fly_q. Histories
//    update every cycle in every state.
//    An input already high when reset releases yields an edge in the first cycle.
//  - Events count only in ACTIVE. The counter updates on the same posedge the edge is
//    seen, so the new value is visible the following cycle. Edges in other states drop.
//  - Simultaneous hit_e & fly_e in one cycle: one bird only; hit wins, misses unchanged.
//  - Counters never exceed BIRDS_PER_ROUND. No edge is counted once birds_used ==
//    BIRDS_PER_ROUND.
//  - FSM:
//    IDLE -> ACTIVE on start_round; per-round counters already 0.
//    ACTIVE -> ROUND_END on the posedge where birds_used reaches BIRDS_PER_ROUND.
//    ROUND_END -> on round_ack:
//      passed & round_num <  MAX_ROUNDS-1 -> IDLE; round_num+1; hits/misses/birds_used cleared.
//      passed & round_num == MAX_ROUNDS-1 -> GAME_OVER; round_passed=1.
//      failed -> GAME_OVER; round_passed=0.
//    GAME_OVER: sticky, all counters frozen; left only by Reset.
//  - round_passed registered on ACTIVE->ROUND_END entry, held through GAME_OVER, cleared on
//    ROUND_END->IDLE.
//  - round_over/game_over are decodes of registered state (no glitch, 0 extra latency).
//  - Reset mid-round (any state) restores the full reset state in one cycle.
//  - All arithmetic unsigned CNT_W bits; round_num saturates at MAX_ROUNDS-1.
// TESTING
//  1) Reset, start_round, 10 hit pulses (1 cycle high, 1 low) -> hits=10, birds_left=0;
//     ROUND_END the cycle after the 10th edge; round_passed=1.
//  2) 5 hits + 5 flew_away pulses -> misses=5, round_passed=0; round_ack -> GAME_OVER,
//     game_over=1.
//  3) bird_hit and flew_away rise in the same cycle -> hits+1, misses+0, birds_used+1.
//  4) bird_hit held high 20 cycles in ACTIVE -> hits=1 only. Pulses in IDLE and ROUND_END
//     -> no count change.
//  5) MAX_ROUNDS=2: pass round 0, ack -> IDLE round_num=1; pass round 1, ack -> GAME_OVER
//     with round_passed=1.
//  6) Reset asserted mid-round with hits=4 -> next cycle all counters 0, state=IDLE.
//     Extra pulse after birds_used=10 -> no overflow.

Source files
------------

// File: rtl/bird_round_keeper.sv
// bird_round_keeper: per-round hit/miss bookkeeping for the duck game.
// Counts rising edges of the sprite's hit/flew-away levels while a round is
// active, decides pass/fail when every bird of the round is accounted for,
// and walks the game through its rounds up to a sticky game-over.
module bird_round_keeper #(
    parameter int BIRDS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int MAX_ROUNDS      = 8,
    parameter int CNT_W           = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_round,
    input  logic             bird_hit,
    input  logic             flew_away,
    input  logic             round_ack,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] birds_used,
    output logic [CNT_W-1:0] birds_left,
    output logic [CNT_W-1:0] round_num,
    output logic             round_over,
    output logic             round_passed,
    output logic             game_over
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ACTIVE    = 2'b01,
        ROUND_END = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] BIRDS      = CNT_W'(BIRDS_PER_ROUND);
    localparam logic [CNT_W-1:0] PASS       = CNT_W'(PASS_HITS);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(MAX_ROUNDS - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           cur_state;
    state_t           nxt_state;
    logic             hit_q;
    logic             fly_q;
    logic             hit_e;
    logic             fly_e;
    logic [CNT_W-1:0] hits_nxt;
    logic [CNT_W-1:0] misses_nxt;
    logic [CNT_W-1:0] used_nxt;
    logic [CNT_W-1:0] round_nxt;
    logic             passed_nxt;

    // Rising-edge detect; history follows the inputs in every state.
    assign hit_e = bird_hit & ~hit_q;
    assign fly_e = flew_away & ~fly_q;

    // Edge history registers.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (Reset) begin
            hit_q <= 1'b0;
            fly_q <= 1'b0;
        end else begin
            hit_q <= bird_hit;
            fly_q <= flew_away;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) cur_state <= IDLE;
        else       cur_state <= nxt_state;
    end

    // Round counters and pass flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hits         <= '0;
            misses       <= '0;
            birds_used   <= '0;
            round_num    <= '0;
            round_passed <= 1'b0;
        end else begin
            hits         <= hits_nxt;
            misses       <= misses_nxt;
            birds_used   <= used_nxt;
            round_num    <= round_nxt;
            round_passed <= passed_nxt;
        end
    end

    // Next-state and next-counter logic; a hit beats a simultaneous escape.
    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no
        // path through the case can leave one unassigned and infer a latch.
        nxt_state  = cur_state;
        hits_nxt   = hits;
        misses_nxt = misses;
        used_nxt   = birds_used;
        round_nxt  = round_num;
        passed_nxt = round_passed;
        unique case (cur_state)
            IDLE: begin
                if (start_round) nxt_state = ACTIVE;
            end
            ACTIVE: begin
                if ((hit_e || fly_e) && (birds_used < BIRDS)) begin
                    used_nxt = birds_used + ONE;
                    if (hit_e) hits_nxt   = hits + ONE;
                    else       misses_nxt = misses + ONE;
                    if (used_nxt == BIRDS) begin
                        nxt_state  = ROUND_END;
                        passed_nxt = (hits_nxt >= PASS);
                    end
                end
            end
            ROUND_END: begin
                if (round_ack) begin
                    if (round_passed && (round_num < LAST_ROUND)) begin
                        nxt_state  = IDLE;
                        round_nxt  = round_num + ONE;
                        hits_nxt   = '0;
                        misses_nxt = '0;
                        used_nxt   = '0;
                        passed_nxt = 1'b0;
                    end else begin
                        nxt_state = GAME_OVER;
                    end
                end
            end
            GAME_OVER: begin
                nxt_state = GAME_OVER;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign state      = cur_state;
    assign birds_left = BIRDS - birds_used;
    assign round_over = (cur_state == ROUND_END);
    assign game_over  = (cur_state == GAME_OVER);

endmodule
